// File: rtl/sdes_cbc_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sdes_cbc_stream_ctrl
// Brief   : Valid/ready byte-stream wrapper around a combinational S-DES core
//           with CBC chaining (define CBC_MODE_EN) or plain ECB (default).
// Revision: 1.0 - initial release
// ============================================================================
module sdes_cbc_stream_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [7:0]  IV_DEFAULT  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  key_in,
    input  logic        key_load,
    input  logic [7:0]  iv_in,
    input  logic        iv_load,
    input  logic [7:0]  in_data,
    input  logic        in_encrypt,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  core_plaintext,
    output logic [9:0]  core_key,
    output logic        core_encrypt,
    input  logic [7:0]  core_ciphertext,
    output logic        busy
);

    localparam int                 c_cnt_w    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [9:0]           r_key;
    logic [7:0]           r_chain;
    logic [7:0]           r_byte;
    logic                 r_enc;
    logic [7:0]           r_pt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [7:0]           r_out_data;
    logic                 r_out_valid;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_release;
    logic [7:0]           w_pt_nxt;
    logic [7:0]           w_out_nxt;

    assign w_idle    = (r_state == S_IDLE);
    assign in_ready  = w_idle && !key_load && !iv_load;
    assign w_accept  = in_valid && in_ready;
    assign w_capture = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_release = (r_state == S_OUTPUT) && r_out_valid && out_ready;

`ifdef CBC_MODE_EN
    assign w_pt_nxt  = in_encrypt ? (in_data ^ r_chain) : in_data;
    assign w_out_nxt = r_enc ? core_ciphertext : (core_ciphertext ^ r_chain);
`else
    // ECB build still maintains the chain register but never consumes it.
    logic w_chain_unused;
    assign w_chain_unused = ^r_chain;
    assign w_pt_nxt       = in_data;
    assign w_out_nxt      = core_ciphertext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)  w_state_nxt = S_WAIT;
            S_WAIT:   if (w_capture) w_state_nxt = S_OUTPUT;
            S_OUTPUT: if (w_release) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key       <= '0;
            r_chain     <= IV_DEFAULT;
            r_byte      <= '0;
            r_enc       <= 1'b0;
            r_pt        <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Config loads and the data accept are mutually exclusive via in_ready.
            if (w_idle && key_load) r_key   <= key_in;
            if (w_idle && iv_load)  r_chain <= iv_in;
            if (w_accept) begin
                r_byte <= in_data;
                r_enc  <= in_encrypt;
                r_pt   <= w_pt_nxt;
                r_cnt  <= c_cnt_load;
            end
            if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_out_data  <= w_out_nxt;
                r_out_valid <= 1'b1;
                r_chain     <= r_enc ? core_ciphertext : r_byte;
            end
            if (w_release) r_out_valid <= 1'b0;
        end
    end

    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign core_plaintext = r_pt;
    assign core_key       = r_key;
    assign core_encrypt   = r_enc;
    assign busy           = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_sdes_cbc_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdes_cbc_stream_ctrl
// Brief   : Bench for sdes_cbc_stream_ctrl with a behavioural S-DES core and
//           byte-level CBC/ECB reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdes_cbc_stream_ctrl;

    localparam int         W   = 3;
    localparam logic [7:0] IVD = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  key_in;
    logic        key_load;
    logic [7:0]  iv_in;
    logic        iv_load;
    logic [7:0]  in_data;
    logic        in_encrypt;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  core_plaintext;
    logic [9:0]  core_key;
    logic        core_encrypt;
    logic [7:0]  core_ciphertext;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  m_key;
    logic [7:0]  m_chain;

    sdes_cbc_stream_ctrl #(.WAIT_CYCLES(W), .IV_DEFAULT(IVD)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_in(key_in), .key_load(key_load),
        .iv_in(iv_in), .iv_load(iv_load),
        .in_data(in_data), .in_encrypt(in_encrypt), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_plaintext(core_plaintext), .core_key(core_key), .core_encrypt(core_encrypt),
        .core_ciphertext(core_ciphertext), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] sbox(input logic [3:0] b, input bit sel);
        logic [1:0] s0 [16];
        logic [1:0] s1 [16];
        logic [3:0] idx;
        s0 = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
               2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
        s1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
               2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
        idx = {b[3], b[0], b[2], b[1]};
        return sel ? s1[idx] : s0[idx];
    endfunction

    function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] sk);
        logic [7:0] e;
        logic [3:0] s;
        logic [3:0] p4;
        e  = {x[0], x[3], x[2], x[1], x[2], x[1], x[0], x[3]} ^ sk;
        s  = {sbox(e[7:4], 1'b0), sbox(e[3:0], 1'b1)};
        p4 = {s[2], s[0], s[1], s[3]};
        return {x[7:4] ^ p4, x[3:0]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] t);
        return {t[4], t[7], t[3], t[6], t[2], t[5], t[0], t[1]};
    endfunction

    function automatic logic [7:0] sdes(input logic [7:0] p, input logic [9:0] k, input logic enc);
        logic [9:0] pk;
        logic [4:0] l1, r1, l2, r2;
        logic [7:0] k1, k2, t;
        pk = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
        l1 = {pk[8:5], pk[9]};
        r1 = {pk[3:0], pk[4]};
        l2 = {l1[2:0], l1[4:3]};
        r2 = {r1[2:0], r1[4:3]};
        k1 = p8({l1, r1});
        k2 = p8({l2, r2});
        t  = {p[6], p[2], p[5], p[7], p[4], p[0], p[3], p[1]};
        t  = fk(t, enc ? k1 : k2);
        t  = {t[3:0], t[7:4]};
        t  = fk(t, enc ? k2 : k1);
        return {t[4], t[7], t[5], t[3], t[1], t[6], t[0], t[2]};
    endfunction

    assign core_ciphertext = sdes(core_plaintext, core_key, core_encrypt);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One byte through the cipher chain as seen from outside.
    task automatic model_xact(input logic [7:0] b, input logic enc, output logic [7:0] exp);
`ifdef CBC_MODE_EN
        if (enc) begin
            exp     = sdes(b ^ m_chain, m_key, 1'b1);
            m_chain = exp;
        end else begin
            exp     = sdes(b, m_key, 1'b0) ^ m_chain;
            m_chain = b;
        end
`else
        exp     = sdes(b, m_key, enc);
        m_chain = enc ? exp : b;
`endif
    endtask

    task automatic load_cfg(input bit do_key, input logic [9:0] k, input bit do_iv, input logic [7:0] iv);
        @(negedge clk);
        key_in = k; key_load = do_key; iv_in = iv; iv_load = do_iv;
        @(negedge clk);
        key_load = 1'b0; iv_load = 1'b0;
        if (do_key) m_key = k;
        if (do_iv)  m_chain = iv;
    endtask

    task automatic send(input logic [7:0] b, input logic enc, input int hold,
                        input bit pulse, input bit busy_key, output logic [7:0] got);
        logic [7:0] exp;
        model_xact(b, enc, exp);
        @(negedge clk);
        in_data = b; in_encrypt = enc; in_valid = 1'b1;
        #1 check("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'($urandom);
        if (busy_key) begin
            key_in = ~m_key; key_load = 1'b1;
        end
        for (int i = 0; i < W - 1; i++) begin
            check("latency_low", out_valid, 0);
            @(negedge clk);
            key_load = 1'b0;
        end
        check("latency_low", out_valid, 0);
        @(negedge clk);
        key_load = 1'b0;
        check("out_valid", out_valid, 1);
        check("out_data", out_data, exp);
        got = out_data;
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 2) begin
                in_data = ~b; in_valid = 1'b1;
                #1 check("bp_in_ready", in_ready, 0);
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("bp_stable", {out_valid, out_data}, {1'b1, exp});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release", {out_valid, busy}, 2'b00);
        check("key_reg", core_key, m_key);
        check("chain", dut.r_chain, m_chain);
    endtask

    initial begin
        logic [7:0] r1, r2, d;
        rst_n = 1'b0; key_in = '0; key_load = 0; iv_in = '0; iv_load = 0;
        in_data = '0; in_encrypt = 0; in_valid = 0; out_ready = 0;
        m_key = '0; m_chain = IVD;
        #12;
        check("rst_out", {out_valid, out_data, busy}, 10'h0);
        check("rst_core", {core_plaintext, core_key, core_encrypt}, 19'h0);
        check("rst_chain", dut.r_chain, IVD);
        @(negedge clk) rst_n = 1'b1;

        // T1 / T2
        load_cfg(1, 10'b1010000010, 1, 8'h00);
        send(8'b10010111, 1, 0, 0, 0, r1);
        check("t1_const", r1, 8'b00111000);
        send(8'b10010111, 1, 0, 0, 0, r2);
`ifdef CBC_MODE_EN
        check("t2_byte2", r2, sdes(8'b10101111, 10'b1010000010, 1'b1));
        check("t2_differ", (r1 != r2), 1);
`endif

        // T3
        load_cfg(0, '0, 1, 8'h00);
        send(r1, 0, 0, 0, 0, d);
        check("t3_pt1", d, 8'b10010111);
        send(r2, 0, 0, 0, 0, d);
        check("t3_pt2", d, 8'b10010111);
        check("t3_chain", dut.r_chain, r2);

        // T4: backpressure with a stray input pulse
        send(8'h5A, 1, 5, 1, 0, d);
        @(negedge clk);
        check("t4_no_accept", {busy, out_valid}, 2'b00);

        // T5: IV load beats data in the same cycle
        @(negedge clk);
        iv_in = 8'hC3; iv_load = 1'b1; in_data = 8'h3C; in_valid = 1'b1; in_encrypt = 1'b1;
        #1 check("t5_in_ready", in_ready, 0);
        @(negedge clk);
        iv_load = 1'b0; in_valid = 1'b0; m_chain = 8'hC3;
        check("t5_not_busy", busy, 0);
        check("t5_iv", dut.r_chain, 8'hC3);
        send(8'h3C, 1, 0, 0, 1, d);
        send(8'hA7, 0, 1, 0, 0, d);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            logic [7:0] rb;
            if ($urandom_range(3) == 0) load_cfg(0, '0, 1, 8'($urandom));
            if ($urandom_range(4) == 0) load_cfg(1, 10'($urandom), 0, '0);
            rb = 8'($urandom);
            send(rb, 1'($urandom), int'($urandom_range(2)), 0, 1'($urandom), d);
        end

        // T6: asynchronous reset while waiting on the core
        @(negedge clk);
        in_data = 8'h77; in_encrypt = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async", {out_valid, busy, core_key}, 12'h0);
        check("t6_chain", dut.r_chain, IVD);
        @(negedge clk) rst_n = 1'b1;
        m_key = '0; m_chain = IVD;
        load_cfg(1, 10'b1010000010, 0, '0);
        send(8'b10010111, 1, 0, 0, 0, d);
        check("t6_t1_again", d, 8'b00111000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
